systolic_result_writer: RTL and testbench

Downstream stage of the systolic array controller. It captures each finished result row when the controller asserts its SRAM write enable. Each row is narrowed from accumulator width to storage width, tagged with an output-SRAM address built from data set and row index, and buffered in a small FIFO. It then drains the rows to the result SRAM over a valid/ready request port that may stall. It reports completion once the controller is done and every buffered row has been written.

---
 rtl/tpu_pkg.sv | 50 +++++
 rtl/result_fifo.sv | 75 +++++++
 rtl/systolic_result_writer.sv | 146 ++++++++++++++
 tb/tb_systolic_result_writer.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tpu_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tpu_pkg
//  Description : Shared types and helpers for the systolic result path:
//                writer FSM state encoding, default lane widths and the
//                accumulator-to-storage lane narrowing function.
//                Build option RESULT_SAT_EN selects saturating narrowing;
//                without it lanes are plainly truncated.
//  Revision    : 1.0 - initial release
// ============================================================================
package tpu_pkg;

    localparam int ACC_WIDTH_DEF = 32;
    localparam int OUT_WIDTH_DEF = 16;

    // Widest lane the narrowing helper handles; callers sign-extend into it.
    localparam int LANE_MAX_W = 64;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACTIVE = 2'd1,
        DRAIN  = 2'd2,
        DONE   = 2'd3
    } wr_state_t;

    // Narrow a sign-extended lane to out_w bits; caller keeps the low out_w bits.
    function automatic logic [LANE_MAX_W-1:0] narrow_lane(
        input logic signed [LANE_MAX_W-1:0] v,
        input int unsigned                  out_w
    );
`ifdef RESULT_SAT_EN
        logic signed [LANE_MAX_W-1:0] hi;
        logic signed [LANE_MAX_W-1:0] lo;
        hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (out_w - 1));
        if (v > hi)
            return hi;
        else if (v < lo)
            return lo;
        else
            return v;
`else
        // Pure truncation: mask only, no magnitude compare.
        return v & ((64'd1 << out_w) - 64'd1);
`endif
    endfunction

endpackage
`default_nettype wire

// File: rtl/result_fifo.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : result_fifo
//  Description : Synchronous FIFO with a registered head word. The head
//                register is loaded with the next-cycle head so a word pushed
//                into an empty FIFO is visible on dout the following cycle.
//                Simultaneous push and pop is legal when full.
//  Revision    : 1.0 - initial release
// ============================================================================
module result_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic [WIDTH-1:0]           din,
    output logic [WIDTH-1:0]           dout,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] rd_ptr_nxt;
    logic [CNT_W-1:0] cnt;
    logic [CNT_W-1:0] cnt_nxt;

    // Next read pointer and occupancy after this cycle's push/pop.
    always_comb begin
        rd_ptr_nxt = rd_ptr + PTR_W'(pop);
        cnt_nxt    = cnt + CNT_W'(push) - CNT_W'(pop);
    end

    assign full  = (cnt == CNT_W'(DEPTH));
    assign count = cnt;

    // Storage array; contents need no reset because occupancy guards reads.
    always_ff @(posedge clk) begin
        if (push)
            mem[wr_ptr] <= din;
    end

    // Pointers, occupancy and the registered head word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            empty  <= 1'b1;
            dout   <= '0;
        end else begin
            wr_ptr <= wr_ptr + PTR_W'(push);
            rd_ptr <= rd_ptr_nxt;
            cnt    <= cnt_nxt;
            empty  <= (cnt_nxt == '0);
            // Empty next cycle: hold the last head so dout stays stable.
            if (cnt_nxt != '0) begin
                if ((cnt - CNT_W'(pop)) == '0)
                    dout <= din;              // only entry is the one being pushed
                else
                    dout <= mem[rd_ptr_nxt];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/systolic_result_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : systolic_result_writer
//  Description : Captures finished result rows from the systolic controller,
//                narrows each lane to storage width, tags the row with an
//                output-SRAM address and buffers it in a small FIFO, then
//                drains rows over a stallable valid/ready request port.
//                Signals completion once the run is done and drained.
//                Build option RESULT_SAT_EN: saturating lane narrowing.
//  Revision    : 1.0 - initial release
// ============================================================================
module systolic_result_writer
    import tpu_pkg::*;
#(
    parameter int ARRAY_SIZE   = 32,
    parameter int ACC_WIDTH    = ACC_WIDTH_DEF,
    parameter int OUT_WIDTH    = OUT_WIDTH_DEF,
    parameter int ROWS_PER_SET = 64,
    parameter int ADDR_WIDTH   = 8,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            wr_en_in,
    input  logic [5:0]                      row_index_in,
    input  logic [1:0]                      data_set_in,
    input  logic [ARRAY_SIZE*ACC_WIDTH-1:0] row_data_in,
    input  logic                            tpu_done_in,
    output logic                            sram_req,
    input  logic                            sram_ready,
    output logic [ADDR_WIDTH-1:0]           sram_addr,
    output logic [ARRAY_SIZE*OUT_WIDTH-1:0] sram_wdata,
    output logic                            busy,
    output logic                            writer_done,
    output logic                            overflow_err
);

    localparam int DATA_W = ARRAY_SIZE * OUT_WIDTH;
    localparam int WORD_W = ADDR_WIDTH + DATA_W;
    localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

    wr_state_t          state;
    logic [DATA_W-1:0]  narrowed;
    logic [ADDR_WIDTH-1:0] row_addr;
    logic [WORD_W-1:0]  fifo_dout;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;
    logic [CNT_W-1:0]   level_nxt;
    logic               push;
    logic               pop;
    logic               fifo_drained;

    // Per-lane narrowing at push time.
    genvar gi;
    generate
        for (gi = 0; gi < ARRAY_SIZE; gi++) begin : g_lane
            assign narrowed[gi*OUT_WIDTH +: OUT_WIDTH] = OUT_WIDTH'(narrow_lane(
                64'(signed'(row_data_in[gi*ACC_WIDTH +: ACC_WIDTH])), OUT_WIDTH));
        end
    endgenerate

    // Full-width address then wrap to the SRAM address width.
    assign row_addr = ADDR_WIDTH'(32'(data_set_in) * 32'(ROWS_PER_SET) + 32'(row_index_in));

    // A full FIFO still accepts a row when the head leaves in the same cycle.
    assign pop          = !fifo_empty && sram_ready;
    assign push         = wr_en_in && (!fifo_full || pop);
    assign level_nxt    = fifo_count + CNT_W'(push) - CNT_W'(pop);
    assign fifo_drained = (level_nxt == '0);

    result_fifo #(
        .WIDTH (WORD_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .din   ({row_addr, narrowed}),
        .dout  (fifo_dout),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    assign {sram_addr, sram_wdata} = fifo_dout;

    // Request valid and sticky drop flag, both registered.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sram_req     <= 1'b0;
            overflow_err <= 1'b0;
        end else begin
            sram_req <= !fifo_drained;
            if (wr_en_in && !push)
                overflow_err <= 1'b1;
        end
    end

    // Run-tracking FSM with registered busy / writer_done.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= IDLE;
            busy        <= 1'b0;
            writer_done <= 1'b0;
        end else begin
            busy        <= 1'b1;
            writer_done <= 1'b0;
            case (state)
                IDLE: begin
                    if (tpu_done_in) begin
                        // Empty run completes at once; a coincident row drains first.
                        state       <= wr_en_in ? DRAIN : DONE;
                        writer_done <= !wr_en_in;
                    end else if (wr_en_in) begin
                        state <= ACTIVE;
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ACTIVE: begin
                    if (tpu_done_in)
                        state <= DRAIN;
                end
                DRAIN: begin
                    if (fifo_drained) begin
                        state       <= DONE;
                        writer_done <= 1'b1;
                    end
                end
                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_systolic_result_writer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_systolic_result_writer
//  Description : Self-checking bench for systolic_result_writer with a
//                queue-based reference model of the buffered row stream.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_systolic_result_writer;

    localparam int AS = 32;
    localparam int AW = 32;
    localparam int OW = 16;
    localparam int IW = AS * AW;
    localparam int DW = AS * OW;
    localparam int WW = 8 + DW;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          wr_en_in;
    logic [5:0]    row_index_in;
    logic [1:0]    data_set_in;
    logic [IW-1:0] row_data_in;
    logic          tpu_done_in;
    logic          sram_ready;
    logic          sram_req;
    logic [7:0]    sram_addr;
    logic [DW-1:0] sram_wdata;
    logic          busy;
    logic          writer_done;
    logic          overflow_err;

    logic          b_req;
    logic [7:0]    b_addr;
    logic [DW-1:0] b_wdata;
    logic          b_busy;
    logic          b_done;
    logic          b_ovf;

    systolic_result_writer u_dut (
        .clk(clk), .rst_n(rst_n), .wr_en_in(wr_en_in), .row_index_in(row_index_in),
        .data_set_in(data_set_in), .row_data_in(row_data_in), .tpu_done_in(tpu_done_in),
        .sram_req(sram_req), .sram_ready(sram_ready), .sram_addr(sram_addr),
        .sram_wdata(sram_wdata), .busy(busy), .writer_done(writer_done),
        .overflow_err(overflow_err)
    );

    systolic_result_writer #(.ROWS_PER_SET(128)) u_dut_r128 (
        .clk(clk), .rst_n(rst_n), .wr_en_in(wr_en_in), .row_index_in(row_index_in),
        .data_set_in(data_set_in), .row_data_in(row_data_in), .tpu_done_in(tpu_done_in),
        .sram_req(b_req), .sram_ready(sram_ready), .sram_addr(b_addr),
        .sram_wdata(b_wdata), .busy(b_busy), .writer_done(b_done),
        .overflow_err(b_ovf)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: queue of {addr, data} words plus run phase.
    logic [WW-1:0] q[$];
    int            m_phase;   // 0 idle, 1 collecting, 2 draining, 3 done
    bit            m_req, m_busy, m_done, m_ovf;
    logic [7:0]    m_addr;
    logic [DW-1:0] m_data;

    function automatic logic [15:0] narrow(input logic [31:0] v);
        int signed s;
        s = signed'(v);
`ifdef RESULT_SAT_EN
        if (s > 32767)  return 16'h7FFF;
        if (s < -32768) return 16'h8000;
`endif
        return v[15:0];
    endfunction

    function automatic logic [WW-1:0] mk_word(input int ds, input int idx, input logic [IW-1:0] r);
        logic [DW-1:0] d;
        logic [7:0]    a;
        a = 8'((ds * 64 + idx) % 256);
        for (int i = 0; i < AS; i++) d[i*OW +: OW] = narrow(r[i*AW +: AW]);
        return {a, d};
    endfunction

    task automatic rand_row(output logic [IW-1:0] r);
        for (int i = 0; i < AS; i++)
            r[i*AW +: AW] = ($urandom_range(0, 2) == 0) ? 32'($urandom) :
                            32'($signed($urandom_range(0, 80000)) - 40000);
    endtask

    task automatic model_reset();
        q.delete();
        m_phase = 0; m_req = 0; m_busy = 0; m_done = 0; m_ovf = 0;
        m_addr = '0; m_data = '0;
    endtask

    // Drive one cycle of inputs and advance the model across the clock edge.
    task automatic step(input bit wr, input int idx, input int ds, input logic [IW-1:0] r,
                        input bit done, input bit rdy);
        int  sz;
        bit  pp, ps;
        logic [WW-1:0] w;
        wr_en_in = wr; row_index_in = 6'(idx); data_set_in = 2'(ds);
        row_data_in = r; tpu_done_in = done; sram_ready = rdy;
        @(posedge clk);
        sz = q.size();
        pp = (sz > 0) && rdy;
        ps = wr && ((sz < 4) || pp);
        if (wr && !ps) m_ovf = 1;
        if (pp) void'(q.pop_front());
        if (ps) q.push_back(mk_word(ds, idx, r));
        case (m_phase)
            0: if (done) m_phase = wr ? 2 : 3; else if (wr) m_phase = 1;
            1: if (done) m_phase = 2;
            2: if (q.size() == 0) m_phase = 3;
            default: m_phase = 0;
        endcase
        m_busy = (m_phase != 0);
        m_done = (m_phase == 3);
        m_req  = (q.size() > 0);
        if (q.size() > 0) begin
            w = q[0];
            m_addr = w[WW-1:DW];
            m_data = w[DW-1:0];
        end
        #1;
    endtask

    task automatic do_reset();
        rst_n = 0; wr_en_in = 0; tpu_done_in = 0; sram_ready = 0;
        row_index_in = '0; data_set_in = '0; row_data_in = '0;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (sram_req !== 1'b0) begin failures++; $display("FAIL reset_req: got %b want 0", sram_req); end
        checks++; if (sram_addr !== 8'd0) begin failures++; $display("FAIL reset_addr: got %0d want 0", sram_addr); end
        checks++; if (sram_wdata !== '0) begin failures++; $display("FAIL reset_wdata: got %h want 0", sram_wdata); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (writer_done !== 1'b0) begin failures++; $display("FAIL reset_done: got %b want 0", writer_done); end
        checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL reset_ovf: got %b want 0", overflow_err); end
    endtask

    task automatic test_single_row();
        logic [IW-1:0] r;
        do_reset();
        rand_row(r);
        step(1, 5, 1, r, 0, 1);
        checks++; if (sram_req !== 1'b1) begin failures++; $display("FAIL single_req: got %b want 1", sram_req); end
        checks++; if (sram_addr !== 8'd69) begin failures++; $display("FAIL single_addr: got %0d want 69", sram_addr); end
        checks++; if (sram_wdata !== m_data) begin failures++; $display("FAIL single_data: got %h want %h", sram_wdata, m_data); end
        step(0, 0, 0, '0, 1, 1);
        checks++; if (sram_req !== 1'b0) begin failures++; $display("FAIL single_one_beat: got %b want 0", sram_req); end
        checks++; if (writer_done !== 1'b0) begin failures++; $display("FAIL single_done_early: got %b want 0", writer_done); end
        step(0, 0, 0, '0, 0, 1);
        checks++; if (writer_done !== 1'b1) begin failures++; $display("FAIL single_done: got %b want 1", writer_done); end
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL single_busy_done: got %b want 1", busy); end
        step(0, 0, 0, '0, 0, 1);
        checks++; if (writer_done !== 1'b0) begin failures++; $display("FAIL single_done_pulse: got %b want 0", writer_done); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL single_idle: got %b want 0", busy); end
    endtask

    task automatic test_lane_conv();
        logic [IW-1:0] r;
        logic [15:0]   e0, e1;
`ifdef RESULT_SAT_EN
        e0 = 16'h7FFF; e1 = 16'h8000;
`else
        e0 = 16'h0000; e1 = 16'hEE90;
`endif
        do_reset();
        rand_row(r);
        r[31:0]  = 32'h0001_0000;
        r[63:32] = 32'hFFFE_EE90;     // -70000
        step(1, 2, 0, r, 0, 1);
        checks++; if (sram_wdata[15:0] !== e0) begin failures++; $display("FAIL lane_pos: got %h want %h", sram_wdata[15:0], e0); end
        checks++; if (sram_wdata[31:16] !== e1) begin failures++; $display("FAIL lane_neg: got %h want %h", sram_wdata[31:16], e1); end
        checks++; if (sram_wdata !== m_data) begin failures++; $display("FAIL lane_row: got %h want %h", sram_wdata, m_data); end
    endtask

    task automatic test_addr_wrap();
        logic [IW-1:0] r;
        do_reset();
        rand_row(r);
        step(1, 63, 3, r, 0, 1);
        checks++; if (sram_addr !== 8'd255) begin failures++; $display("FAIL wrap_255: got %0d want 255", sram_addr); end
        checks++; if (b_addr !== 8'd191) begin failures++; $display("FAIL wrap_r128_447: got %0d want 191", b_addr); end
        step(1, 0, 2, r, 0, 1);
        checks++; if (sram_addr !== 8'd128) begin failures++; $display("FAIL wrap_128: got %0d want 128", sram_addr); end
        checks++; if (b_addr !== 8'd0) begin failures++; $display("FAIL wrap_r128_0: got %0d want 0", b_addr); end
        checks++; if (b_req !== 1'b1) begin failures++; $display("FAIL wrap_r128_req: got %b want 1", b_req); end
    endtask

    task automatic test_overflow();
        logic [IW-1:0] rr [5];
        logic [WW-1:0] w;
        do_reset();
        for (int k = 0; k < 5; k++) begin
            rand_row(rr[k]);
            step(1, k, 1, rr[k], 0, 0);
            checks++; if (overflow_err !== (k == 4)) begin failures++; $display("FAIL ovf_flag_%0d: got %b want %b", k, overflow_err, (k == 4)); end
            checks++; if (sram_addr !== 8'd64) begin failures++; $display("FAIL ovf_hold_addr_%0d: got %0d want 64", k, sram_addr); end
        end
        for (int k = 0; k < 4; k++) begin
            w = mk_word(1, k, rr[k]);
            checks++; if (sram_req !== 1'b1) begin failures++; $display("FAIL ovf_drain_req_%0d: got %b want 1", k, sram_req); end
            checks++; if ({sram_addr, sram_wdata} !== w) begin failures++; $display("FAIL ovf_drain_row_%0d: got addr %0d want %0d", k, sram_addr, w[WW-1:DW]); end
            step(0, 0, 0, '0, 0, 1);
        end
        checks++; if (sram_req !== 1'b0) begin failures++; $display("FAIL ovf_drained: got %b want 0", sram_req); end
        checks++; if (overflow_err !== 1'b1) begin failures++; $display("FAIL ovf_sticky: got %b want 1", overflow_err); end
    endtask

    task automatic test_full_push_pop();
        logic [IW-1:0] rr [5];
        logic [WW-1:0] w;
        do_reset();
        for (int k = 0; k < 4; k++) begin
            rand_row(rr[k]);
            step(1, k, 2, rr[k], 0, 0);
        end
        rand_row(rr[4]);
        step(1, 4, 2, rr[4], 0, 1);
        checks++; if (overflow_err !== 1'b0) begin failures++; $display("FAIL full_pp_ovf: got %b want 0", overflow_err); end
        for (int k = 1; k < 5; k++) begin
            w = mk_word(2, k, rr[k]);
            checks++; if ({sram_req, sram_addr, sram_wdata} !== {1'b1, w}) begin failures++; $display("FAIL full_pp_row_%0d: got req %b addr %0d want addr %0d", k, sram_req, sram_addr, w[WW-1:DW]); end
            step(0, 0, 0, '0, 0, 1);
        end
        checks++; if (sram_req !== 1'b0) begin failures++; $display("FAIL full_pp_empty: got %b want 0", sram_req); end
    endtask

    task automatic test_reset_in_drain();
        logic [IW-1:0] r;
        do_reset();
        for (int k = 0; k < 2; k++) begin
            rand_row(r);
            step(1, k, 0, r, 0, 0);
        end
        step(0, 0, 0, '0, 1, 0);
        checks++; if (busy !== 1'b1) begin failures++; $display("FAIL drain_busy: got %b want 1", busy); end
        rst_n = 0; sram_ready = 1;
        @(posedge clk);
        #1;
        model_reset();
        rst_n = 1;
        checks++; if ({sram_req, busy, writer_done, overflow_err} !== 4'b0000) begin failures++; $display("FAIL drain_rst_flags: got %b want 0000", {sram_req, busy, writer_done, overflow_err}); end
        checks++; if ({sram_addr, sram_wdata} !== '0) begin failures++; $display("FAIL drain_rst_bus: got addr %0d want 0", sram_addr); end
        for (int k = 0; k < 4; k++) begin
            step(0, 0, 0, '0, 0, 1);
            checks++; if (sram_req !== 1'b0) begin failures++; $display("FAIL drain_rst_noreq_%0d: got %b want 0", k, sram_req); end
        end
    endtask

    task automatic test_random();
        logic [IW-1:0] r;
        bit wr, rdy, dn;
        do_reset();
        for (int n = 0; n < 300; n++) begin
            rand_row(r);
            wr  = ($urandom_range(0, 2) != 0);
            rdy = ($urandom_range(0, 1) != 0);
            dn  = ($urandom_range(0, 15) == 0);
            step(wr, int'($urandom_range(0, 63)), int'($urandom_range(0, 3)), r, dn, rdy);
            checks++; if (sram_req !== m_req) begin failures++; $display("FAIL rnd_req@%0d: got %b want %b", n, sram_req, m_req); end
            checks++; if (sram_addr !== m_addr) begin failures++; $display("FAIL rnd_addr@%0d: got %0d want %0d", n, sram_addr, m_addr); end
            checks++; if (sram_wdata !== m_data) begin failures++; $display("FAIL rnd_data@%0d: got %h want %h", n, sram_wdata[63:0], m_data[63:0]); end
            checks++; if (busy !== m_busy) begin failures++; $display("FAIL rnd_busy@%0d: got %b want %b", n, busy, m_busy); end
            checks++; if (writer_done !== m_done) begin failures++; $display("FAIL rnd_done@%0d: got %b want %b", n, writer_done, m_done); end
            checks++; if (overflow_err !== m_ovf) begin failures++; $display("FAIL rnd_ovf@%0d: got %b want %b", n, overflow_err, m_ovf); end
        end
    endtask

    initial begin
        rst_n = 0;
        model_reset();
        test_reset();
        test_single_row();
        test_lane_conv();
        test_addr_wrap();
        test_overflow();
        test_full_push_pop();
        test_reset_in_drain();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
